// File: rtl/uart_rx_if.sv
// Bus-side interface of the UART receiver.
//   rx_data   : received byte, valid while rx_valid=1
//   rx_valid  : holding register occupied
//   rx_ready  : consumer accepts rx_data when rx_valid && rx_ready at a clk edge
//   frame_err : one-cycle pulse, stop bit sampled low
//   overrun   : one-cycle pulse, byte completed while the holding register was full
// master = receiver side, slave = consumer side.
interface uart_rx_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       frame_err;
   logic       overrun;

   modport master (
      output rx_data,
      output rx_valid,
      output frame_err,
      output overrun,
      input  rx_ready
   );

   modport slave (
      input  rx_data,
      input  rx_valid,
      input  frame_err,
      input  overrun,
      output rx_ready
   );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a one-entry valid/ready holding register.
//   clk    : system clock, rising edge
//   resetn : asynchronous active-low reset
//   rx     : raw serial line, asynchronous to clk, idle high
//   bus    : uart_rx_if.master (rx_data, rx_valid, rx_ready, frame_err, overrun)
// CLKDIV clocks per bit (>= 4, up to 65535); LSB first, one start and one stop bit.
module uart_rx #(
   parameter int unsigned CLKDIV = 12
) (
   input  logic      clk,
   input  logic      resetn,
   input  logic      rx,
   uart_rx_if.master bus
);

   localparam logic [15:0] FullReload = 16'(CLKDIV - 1);
   localparam logic [15:0] HalfReload = 16'((CLKDIV / 2) - 1);

   typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

   state_e      state_q, state_d;
   logic        rx_meta, rx_s, rx_d;
   logic [15:0] baud_q;
   logic [2:0]  bit_q;
   logic [7:0]  shreg_q;
   logic        done_q;
   logic [7:0]  data_q;
   logic        valid_q;
   logic        frame_err_q;
   logic        overrun_q;

   logic fall, tick;
   logic load_half, load_full, bit_clr, shift_en, stop_ok, stop_bad;

   assign fall = ~rx_s & rx_d;
   assign tick = (baud_q == 16'd0);

   // Two-flop synchronizer plus one delay flop for edge detection; idle-high preset.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         rx_d    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
         rx_d    <= rx_s;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (fall) state_d = StStart;
         StStart: if (tick) state_d = rx_s ? StIdle : StData;
         StData:  if (tick && (bit_q == 3'd7)) state_d = StStop;
         StStop:  if (tick) state_d = rx_s ? StIdle : StBreak;
         StBreak: if (rx_s) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Datapath control strobes.
   always_comb begin
      load_half = 1'b0;
      load_full = 1'b0;
      bit_clr   = 1'b0;
      shift_en  = 1'b0;
      stop_ok   = 1'b0;
      stop_bad  = 1'b0;
      unique case (state_q)
         StIdle: load_half = fall;
         StStart: begin
            load_full = tick & ~rx_s;
            bit_clr   = tick & ~rx_s;
         end
         StData: begin
            shift_en  = tick;
            load_full = tick;
         end
         StStop: begin
            stop_ok  = tick & rx_s;
            stop_bad = tick & ~rx_s;
         end
         default: ;
      endcase
   end

   // Baud counter, bit index and shift register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         baud_q      <= 16'd0;
         bit_q       <= 3'd0;
         shreg_q     <= 8'h00;
         done_q      <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         if (load_half) begin
            baud_q <= HalfReload;
         end else if (load_full) begin
            baud_q <= FullReload;
         end else if (!tick) begin
            baud_q <= baud_q - 16'd1;
         end
         if (bit_clr) begin
            bit_q <= 3'd0;
         end else if (shift_en) begin
            bit_q <= bit_q + 3'd1;
         end
         if (shift_en) begin
            shreg_q <= {rx_s, shreg_q[7:1]};
         end
         done_q      <= stop_ok;
         frame_err_q <= stop_bad;
      end
   end

   // Holding register: a completing byte may replace one being drained in the same cycle.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         data_q    <= 8'h00;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         overrun_q <= 1'b0;
         if (done_q) begin
            if (!valid_q || bus.rx_ready) begin
               data_q  <= shreg_q;
               valid_q <= 1'b1;
            end else begin
               overrun_q <= 1'b1;
            end
         end else if (valid_q && bus.rx_ready) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign bus.rx_data   = data_q;
   assign bus.rx_valid  = valid_q;
   assign bus.frame_err = frame_err_q;
   assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized byte streams,
// checked against a frame-level model (byte queue, pulse counts, latency arithmetic).
module tb_uart_rx;
   localparam int unsigned C   = 12;
   localparam int unsigned H   = C / 2;
   // Edges from driving the start bit to rx_valid first reading 1.
   localparam int unsigned LAT = 3 + H + 9 * C + 1;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   logic rx = 1'b1;

   uart_rx_if bus ();

   uart_rx #(.CLKDIV(C)) dut (
      .clk    (clk),
      .resetn (resetn),
      .rx     (rx),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_vec = 0;
   int n_err = 0;
   logic [7:0] got[$];
   logic [7:0] exp_q[$];
   int fe_cnt = 0;
   int ov_cnt = 0;
   int last_rise = -1;
   logic prev_valid = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Observer: records accepted bytes, error pulses and rx_valid rise times.
   always @(negedge clk) begin
      if (bus.rx_valid && !prev_valid) last_rise = cyc;
      prev_valid = bus.rx_valid;
      if (bus.rx_valid && bus.rx_ready) got.push_back(bus.rx_data);
      if (bus.frame_err) fe_cnt++;
      if (bus.overrun) ov_cnt++;
      if (bus.frame_err || bus.overrun)
         check_eq("err_exclusive", 32'(bus.frame_err & bus.overrun), 32'd0);
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      rx = 1'b0;
      wait_cycles(C);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         wait_cycles(C);
      end
      rx = stop;
      wait_cycles(C);
   endtask

   task automatic drain();
      bus.rx_ready = 1'b1;
      wait_cycles(1);
      bus.rx_ready = 1'b0;
   endtask

   task automatic compare_queues(input string tag);
      check_eq({tag, "_count"}, 32'(got.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got.size(); i++)
         check_eq({tag, "_byte"}, 32'(got[i]), 32'(exp_q[i]));
      got.delete();
      exp_q.delete();
   endtask

   initial begin
      int e, fe0, ov0, gap;
      logic [7:0] b;
      logic [7:0] pat[4];
      bit done;
      bus.rx_ready = 1'b0;

      // Reset state
      #12;
      check_eq("rst_valid", 32'(bus.rx_valid), 32'd0);
      check_eq("rst_data", 32'(bus.rx_data), 32'd0);
      check_eq("rst_ferr", 32'(bus.frame_err), 32'd0);
      check_eq("rst_ovr", 32'(bus.overrun), 32'd0);
      resetn = 1'b1;
      wait_cycles(3);

      // Single byte with latency
      e = cyc;
      send_frame(8'h41, 1'b1);
      check_eq("lat_rise", 32'(last_rise), 32'(e + LAT));
      check_eq("single_valid", 32'(bus.rx_valid), 32'd1);
      check_eq("single_data", 32'(bus.rx_data), 32'h41);
      drain();
      check_eq("single_drop", 32'(bus.rx_valid), 32'd0);
      exp_q.push_back(8'h41);
      compare_queues("single");

      // Back-to-back, ready held high
      fe0 = fe_cnt; ov0 = ov_cnt;
      pat[0] = 8'h00; pat[1] = 8'hFF; pat[2] = 8'h55; pat[3] = 8'hAA;
      bus.rx_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(pat[i]);
         send_frame(pat[i], 1'b1);
      end
      wait_cycles(C);
      bus.rx_ready = 1'b0;
      compare_queues("b2b");
      check_eq("b2b_ferr", 32'(fe_cnt - fe0), 32'd0);
      check_eq("b2b_ovr", 32'(ov_cnt - ov0), 32'd0);

      // Glitch rejection
      fe0 = fe_cnt; ov0 = ov_cnt;
      rx = 1'b0;
      wait_cycles(3);
      rx = 1'b1;
      wait_cycles(2 * C);
      check_eq("glitch_valid", 32'(bus.rx_valid), 32'd0);
      check_eq("glitch_ferr", 32'(fe_cnt - fe0), 32'd0);
      check_eq("glitch_ovr", 32'(ov_cnt - ov0), 32'd0);

      // Framing error followed by a held-low line
      fe0 = fe_cnt; ov0 = ov_cnt;
      send_frame(8'h3C, 1'b0);
      wait_cycles(100);
      rx = 1'b1;
      wait_cycles(C);
      check_eq("ferr_count", 32'(fe_cnt - fe0), 32'd1);
      check_eq("ferr_valid", 32'(bus.rx_valid), 32'd0);
      check_eq("ferr_ovr", 32'(ov_cnt - ov0), 32'd0);
      send_frame(8'h3C, 1'b1);
      wait_cycles(2);
      check_eq("ferr_recover_valid", 32'(bus.rx_valid), 32'd1);
      check_eq("ferr_recover_data", 32'(bus.rx_data), 32'h3C);
      drain();
      exp_q.push_back(8'h3C);
      compare_queues("ferr");

      // Overrun: second byte dropped
      ov0 = ov_cnt;
      send_frame(8'h11, 1'b1);
      send_frame(8'h22, 1'b1);
      wait_cycles(2);
      check_eq("ovr_count", 32'(ov_cnt - ov0), 32'd1);
      check_eq("ovr_data", 32'(bus.rx_data), 32'h11);
      check_eq("ovr_valid", 32'(bus.rx_valid), 32'd1);
      drain();
      check_eq("ovr_drained", 32'(bus.rx_valid), 32'd0);
      exp_q.push_back(8'h11);

      // Drain exactly in the completion cycle: no overrun, new byte replaces old
      ov0 = ov_cnt;
      send_frame(8'h11, 1'b1);
      e = cyc;
      fork
         send_frame(8'h22, 1'b1);
         begin
            wait_cycles(LAT - 1);
            bus.rx_ready = 1'b1;
            wait_cycles(1);
            bus.rx_ready = 1'b0;
         end
      join
      check_eq("swap_ovr", 32'(ov_cnt - ov0), 32'd0);
      check_eq("swap_data", 32'(bus.rx_data), 32'h22);
      check_eq("swap_valid", 32'(bus.rx_valid), 32'd1);
      drain();
      exp_q.push_back(8'h11);
      exp_q.push_back(8'h22);
      compare_queues("ovr");

      // Asynchronous reset in the middle of data bit 4
      send_frame(8'h5A, 1'b1);
      b = 8'hC3;
      rx = 1'b0;
      wait_cycles(C);
      for (int i = 0; i < 4; i++) begin
         rx = b[i];
         wait_cycles(C);
      end
      rx = b[4];
      wait_cycles(H);
      #2;
      resetn = 1'b0;
      #1;
      check_eq("arst_valid", 32'(bus.rx_valid), 32'd0);
      check_eq("arst_data", 32'(bus.rx_data), 32'd0);
      check_eq("arst_ferr", 32'(bus.frame_err), 32'd0);
      check_eq("arst_ovr", 32'(bus.overrun), 32'd0);
      wait_cycles(3);
      rx = 1'b1;
      resetn = 1'b1;
      wait_cycles(2 * C);
      fe0 = fe_cnt; ov0 = ov_cnt;
      send_frame(8'h7E, 1'b1);
      wait_cycles(2);
      check_eq("arst_new_data", 32'(bus.rx_data), 32'h7E);
      check_eq("arst_new_valid", 32'(bus.rx_valid), 32'd1);
      check_eq("arst_ferr_cnt", 32'(fe_cnt - fe0), 32'd0);
      check_eq("arst_ovr_cnt", 32'(ov_cnt - ov0), 32'd0);
      drain();
      exp_q.push_back(8'h7E);
      compare_queues("arst");

      // Randomized bytes, random gaps, random ready
      fe0 = fe_cnt; ov0 = ov_cnt;
      done = 1'b0;
      fork
         begin
            for (int i = 0; i < 24; i++) begin
               b = 8'($urandom_range(0, 255));
               gap = int'($urandom_range(0, 2 * C));
               exp_q.push_back(b);
               send_frame(b, 1'b1);
               if (gap > 0) wait_cycles(gap);
            end
            wait_cycles(C);
            done = 1'b1;
         end
         begin
            while (!done) begin
               bus.rx_ready = 1'($urandom_range(0, 1));
               wait_cycles(1);
            end
         end
      join
      bus.rx_ready = 1'b1;
      wait_cycles(2);
      bus.rx_ready = 1'b0;
      wait_cycles(1);
      compare_queues("rand");
      check_eq("rand_ferr", 32'(fe_cnt - fe0), 32'd0);
      check_eq("rand_ovr", 32'(ov_cnt - ov0), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver for the SoC's serial input pin (fpga_pin2 / serial_input).
- Counterpart of the UART transmit path that drives serial_print. It uses the same bit timing: CLKDIV clocks per bit, LSB first, one start bit, one stop bit.
- Delivers received bytes to the bus-side register logic through a one-entry valid/ready holding register, and reports framing and overrun errors.

Parameters:
- CLKDIV, 12, clocks per bit. Legal range is 4 and up. Values 4..65535 must work with the counter width used.

Ports:
- clk  input  1  system clock; all logic on rising edge
- resetn  input  1  asynchronous, active-low reset
- rx  input  1  raw serial line, asynchronous to clk, idle high
- rx_data  output  8  received byte; valid while rx_valid=1
- rx_valid  output  1  holding register occupied
- rx_ready  input  1  consumer accepts rx_data when rx_valid && rx_ready at a clk edge
- frame_err  output  1  one-cycle pulse: stop bit sampled low
- overrun  output  1  one-cycle pulse: byte completed while holding register full and not being drained

Behaviour:
- Reset (resetn=0, asynchronous):
  - state=IDLE; rx_data=8'h00; rx_valid=0; frame_err=0; overrun=0.
  - Synchronizer flops preset to 1; bit counter and baud counter cleared.
- Reset mid-frame aborts the frame silently; no pulse is emitted.
- Input synchronization:
  - rx passes through 2 flops to give rx_s, then 1 more flop to give rx_d for edge detection.
  - All decisions use rx_s.
- Timing reference: t0 is the first clk edge where rx_s=0 and rx_d=1 in IDLE.
- States:
  - IDLE: on falling edge go to START and load baud counter for a half bit, sampling at t0+CLKDIV/2 (integer division).
  - START: at mid-bit sample rx_s.
    - 0: go to DATA, bit index=0.
    - 1: false start (glitch); back to IDLE with no output.
  - DATA: sample bit i at t0+CLKDIV/2+(i+1)*CLKDIV for i=0..7. Shift in LSB first: shreg={rx_s, shreg[7:1]}. After bit 7, go to STOP.
  - STOP: sample at t0+CLKDIV/2+9*CLKDIV.
    - 1: complete; go to IDLE.
    - 0: frame_err pulses the next cycle, the byte is discarded, go to BREAK.
  - BREAK: wait until rx_s=1, then go to IDLE. A held-low line produces exactly one frame_err, not a stream of frames.
- Completion, evaluated in the cycle after a valid stop sample:
  - rx_valid=0: rx_data<=shreg, rx_valid<=1.
  - rx_valid=1 and rx_ready=1 in that same cycle: the old byte is consumed, the new byte is loaded, and rx_valid stays 1 with no overrun.
  - rx_valid=1 and rx_ready=0: the new byte is dropped, rx_data is unchanged, overrun pulses for 1 cycle.
- Latency: for CLKDIV=12, the stop sample is at t0+114 and rx_valid first reads 1 at t0+115.
- Handshake:
  - rx_valid drops the cycle after rx_valid && rx_ready.
  - rx_data is stable while rx_valid=1.
  - rx_ready while rx_valid=0 has no effect.
- Back-to-back frames: a new start edge is accepted from IDLE in the cycle immediately after the STOP sample. There is no extra idle requirement beyond the stop bit half that remains.
- Baud counter: reload value CLKDIV-1, decrement, sample at 0. Odd CLKDIV is allowed; the half-bit uses floor division.
- frame_err and overrun are never asserted in the same cycle.

Test Plan:
- Single byte: drive 0x41 ('A') at 12 clk/bit with rx_ready=0 → rx_valid rises at t0+115 with rx_data=8'h41. Assert rx_ready for 1 cycle → rx_valid=0 the next cycle.
- Back-to-back: send 0x00, 0xFF, 0x55, 0xAA with no idle gaps, rx_ready held 1 → four valid handshakes in order with the exact bytes; no errors.
- Glitch rejection: pulse rx low for 3 clocks → no state change past START; rx_valid, frame_err and overrun all stay 0.
- Framing error:
  - Send 0x3C with the stop bit low, then hold rx low for 100 clks → exactly one frame_err pulse and rx_valid stays 0.
  - Release rx, then send 0x3C correctly → rx_data=8'h3C.
- Overrun:
  - Send 0x11 with rx_ready=0, then send 0x22 → overrun pulses once and rx_data stays 8'h11.
  - Repeat with rx_ready=1 exactly in the 0x22 completion cycle → rx_data=8'h22, rx_valid=1, no overrun.
- Async reset: assert resetn=0 mid-data-bit 4 of a frame → all outputs are 0 immediately. Release, then send 0x7E → rx_data=8'h7E with no spurious pulses.
